// File: rtl/arb2_mux_stage_pkg.sv
// Shared encodings for the two-input arbitration stage: output register
// states, source indices and the priority value after reset.
package arb2_mux_stage_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    localparam logic SRC_IN0    = 1'b0;
    localparam logic SRC_IN1    = 1'b1;
    localparam logic PRIO_RESET = SRC_IN0;

endpackage

// File: rtl/multiplexor.sv
// Plain 2:1 word multiplexor: sel=0 passes in0, sel=1 passes in1.
module multiplexor #(
    parameter int WIDTH = 5
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] mux_out
);

    assign mux_out = sel ? in1 : in0;

endmodule

// File: rtl/arb2_mux_stage.sv
// Round-robin arbiter for two valid/ready producers feeding one registered
// valid/ready output; each output word carries the index of its producer.
module arb2_mux_stage
    import arb2_mux_stage_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1,
    output logic             in1_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    out_state_t       r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_src;
    logic             r_prio;

    logic             w_grant;
    logic             w_load;
    logic [WIDTH-1:0] w_muxOut;

    // A lone requester wins outright; contention or idle falls back to prio.
    always_comb begin
        w_grant = r_prio;
        if (in0_valid && !in1_valid) begin
            w_grant = SRC_IN0;
        end else if (!in0_valid && in1_valid) begin
            w_grant = SRC_IN1;
        end
    end

    // Gated by rst so nothing is offered or accepted while reset is held.
    assign w_load = !rst && ((r_state == ST_EMPTY) || out_ready)
                    && (in0_valid || in1_valid);

    assign sel       = rst ? SRC_IN0 : w_grant;
    assign in0_ready = w_load && (w_grant == SRC_IN0);
    assign in1_ready = w_load && (w_grant == SRC_IN1);

    multiplexor #(
        .WIDTH(WIDTH)
    ) u_mux (
        .sel     (sel),
        .in0     (in0),
        .in1     (in1),
        .mux_out (w_muxOut)
    );

    // Priority only moves on an accepted word, so a lone requester hands it over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_src   <= SRC_IN0;
            r_prio  <= PRIO_RESET;
        end else if (w_load) begin
            r_state <= ST_FULL;
            r_data  <= w_muxOut;
            r_src   <= w_grant;
            r_prio  <= ~w_grant;
        end else if (out_ready && (r_state == ST_FULL)) begin
            r_state <= ST_EMPTY;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule

// File: tb/tb_arb2_mux_stage.sv
// Directed self-checking bench for arb2_mux_stage with WIDTH=5.
module tb_arb2_mux_stage;

    logic       clk;
    logic       rst;
    logic       in0_valid;
    logic [4:0] in0;
    logic       in0_ready;
    logic       in1_valid;
    logic [4:0] in1;
    logic       in1_ready;
    logic       sel;
    logic       out_valid;
    logic [4:0] out_data;
    logic       out_src;
    logic       out_ready;

    int tests;
    int failed;

    arb2_mux_stage #(.WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0       (in0),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1       (in1),
        .in1_ready (in1_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0       = 5'h00;
        in1       = 5'h00;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        doReset();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        tests++; if (out_data !== 5'h00) begin failed++; $display("[TB] FAIL reset_data: got %h expected 00", out_data); end
        tests++; if (out_src !== 1'b0) begin failed++; $display("[TB] FAIL reset_src: got %b expected 0", out_src); end
    endtask

    task automatic test_single();
        doReset();
        in0_valid = 1'b1; in0 = 5'h15; out_ready = 1'b1;
        #1;
        tests++; if ({in0_ready, in1_ready} !== 2'b10) begin failed++; $display("[TB] FAIL single_ready: got %b expected 10", {in0_ready, in1_ready}); end
        tests++; if (sel !== 1'b0) begin failed++; $display("[TB] FAIL single_sel: got %b expected 0", sel); end
        tick();
        in0_valid = 1'b0;
        #1;
        tests++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 5'h15}) begin failed++; $display("[TB] FAIL single_out: got v=%b s=%b d=%h expected v=1 s=0 d=15", out_valid, out_src, out_data); end
        // With no requester sel shows prio, which must now be 1
        tests++; if (sel !== 1'b1) begin failed++; $display("[TB] FAIL single_prio: got %b expected 1", sel); end
    endtask

    task automatic test_alternation();
        logic [3:0] expSrc;
        expSrc = 4'b1010;
        doReset();
        in0_valid = 1'b1; in0 = 5'h0A;
        in1_valid = 1'b1; in1 = 5'h03;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if ({in1_ready, in0_ready} !== (expSrc[i] ? 2'b10 : 2'b01)) begin failed++; $display("[TB] FAIL alt_ready[%0d]: got in0=%b in1=%b expected src %b", i, in0_ready, in1_ready, expSrc[i]); end
            tick();
            tests++; if ({out_valid, out_src, out_data} !== {1'b1, expSrc[i], (expSrc[i] ? 5'h03 : 5'h0A)}) begin failed++; $display("[TB] FAIL alt_out[%0d]: got v=%b s=%b d=%h expected v=1 s=%b", i, out_valid, out_src, out_data, expSrc[i]); end
        end
    endtask

    task automatic test_backpressure();
        doReset();
        in1_valid = 1'b1; in1 = 5'h15; out_ready = 1'b1;
        tick();
        in0_valid = 1'b1; in0 = 5'h0A; in1 = 5'h1F; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if ({in0_ready, in1_ready} !== 2'b00) begin failed++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 00", i, {in0_ready, in1_ready}); end
            tests++; if (sel !== 1'b0) begin failed++; $display("[TB] FAIL bp_prio[%0d]: got %b expected 0", i, sel); end
            tick();
            tests++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, 5'h15}) begin failed++; $display("[TB] FAIL bp_hold[%0d]: got v=%b s=%b d=%h expected v=1 s=1 d=15", i, out_valid, out_src, out_data); end
        end
        out_ready = 1'b1;
        #1;
        tests++; if ({in0_ready, in1_ready} !== 2'b10) begin failed++; $display("[TB] FAIL bp_release_ready: got %b expected 10", {in0_ready, in1_ready}); end
        tick();
        tests++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 5'h0A}) begin failed++; $display("[TB] FAIL bp_release_out: got v=%b s=%b d=%h expected v=1 s=0 d=0A", out_valid, out_src, out_data); end
    endtask

    task automatic test_back_to_back();
        doReset();
        in0_valid = 1'b1; in0 = 5'h11; out_ready = 1'b1;
        tick();
        in0_valid = 1'b0; in1_valid = 1'b1; in1 = 5'h0A;
        #1;
        tests++; if ({in0_ready, in1_ready} !== 2'b01) begin failed++; $display("[TB] FAIL b2b_ready: got %b expected 01", {in0_ready, in1_ready}); end
        tick();
        tests++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, 5'h0A}) begin failed++; $display("[TB] FAIL b2b_out: got v=%b s=%b d=%h expected v=1 s=1 d=0A", out_valid, out_src, out_data); end
    endtask

    task automatic test_drain();
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("[TB] FAIL drain_valid: got %b expected 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            out_ready = ~out_ready;
            tick();
            tests++; if ({out_valid, in0_ready, in1_ready, out_data} !== {3'b000, 5'h0A}) begin failed++; $display("[TB] FAIL drain_idle[%0d]: got v=%b r=%b%b d=%h expected v=0 r=00 d=0A", i, out_valid, in0_ready, in1_ready, out_data); end
        end
    endtask

    task automatic test_reset_midstream();
        doReset();
        in0_valid = 1'b1; in0 = 5'h1C; out_ready = 1'b1;
        tick();
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests++; if ({out_valid, out_src, out_data} !== {1'b0, 1'b0, 5'h00}) begin failed++; $display("[TB] FAIL midrst_out: got v=%b s=%b d=%h expected v=0 s=0 d=00", out_valid, out_src, out_data); end
        tests++; if ({in0_ready, in1_ready, sel} !== 3'b000) begin failed++; $display("[TB] FAIL midrst_ctrl: got r=%b%b sel=%b expected r=00 sel=0", in0_ready, in1_ready, sel); end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        tests++; if ({in0_ready, in1_ready} !== 2'b10) begin failed++; $display("[TB] FAIL midrst_first: got %b expected 10", {in0_ready, in1_ready}); end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_single();
        test_alternation();
        test_backpressure();
        test_back_to_back();
        test_drain();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
